// File: rtl/alu_mdu.sv
// alu_mdu: iterative signed/unsigned multiply-divide unit with HI/LO registers.
// Optional MDU_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module alu_mdu #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rega,
    input  logic [DATA_WIDTH-1:0] regb,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0] acc, mc, prod;
    logic [W-1:0] mq, abs_a, abs_b, rem_nx, quo_nx;
    logic [W:0] trial;
    logic s_q, s_r, dbz, ready, accept, is_mul, is_div, is_sgn, zero_b, last;

    always_comb begin
        ready  = state == IDLE || state == DONE;
        accept = ready && start && op < 3'd6;
        is_mul = op[2:1] == 2'b00;
        is_div = op[2:1] == 2'b01;
        is_sgn = op[0] && !op[2];
        zero_b = regb == '0;
        abs_a  = (is_sgn && rega[W-1]) ? -rega : rega;
        abs_b  = (is_sgn && regb[W-1]) ? -regb : regb;
`ifdef MDU_EARLY_TERM_EN
        last   = cnt == CNT_WIDTH'(W - 1) || (state == MUL && mq[W-1:1] == '0);
`else
        last   = cnt == CNT_WIDTH'(W - 1);
`endif
        prod   = acc + (mq[0] ? mc : '0);
        // restoring step: shift the next dividend bit into the remainder, try subtracting
        trial  = {acc[W-1:0], mq[W-1]} - {1'b0, mc[W-1:0]};
        rem_nx = trial[W] ? {acc[W-2:0], mq[W-1]} : trial[W-1:0];
        quo_nx = {mq[W-2:0], ~trial[W]};
    end

    always_comb begin
        state_nx = state;
        if (ready)
            state_nx = !accept ? IDLE : is_mul ? MUL : (is_div && !zero_b) ? DIV : DONE;
        else
            state_nx = last ? DONE : state;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            mc  <= '0;
            mq  <= '0;
            s_q <= 1'b0;
            s_r <= 1'b0;
            dbz <= 1'b0;
            hi  <= '0;
            lo  <= '0;
        end else begin
            dbz <= accept && is_div && zero_b;
            if (accept) begin
                cnt <= '0;
                acc <= '0;
                mc  <= {{W{1'b0}}, is_div ? abs_b : abs_a};
                mq  <= is_div ? abs_a : abs_b;
                s_q <= is_sgn && (rega[W-1] ^ regb[W-1]);
                s_r <= is_sgn && rega[W-1];
                if (op == 3'd4) hi <= rega;
                if (op == 3'd5) lo <= rega;
            end else if (state == MUL) begin
                acc <= prod;
                mc  <= mc << 1;
                mq  <= mq >> 1;
                cnt <= cnt + 1'b1;
                if (last) {hi, lo} <= s_q ? -prod : prod;
            end else if (state == DIV) begin
                acc <= {{W{1'b0}}, rem_nx};
                mq  <= quo_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    lo <= s_q ? -quo_nx : quo_nx;
                    hi <= s_r ? -rem_nx : rem_nx;
                end
            end
        end
    end

    assign busy        = state == MUL || state == DIV;
    assign done        = state == DONE;
    assign div_by_zero = dbz;
endmodule
